// File: rtl/bus_dma_initiator.sv
// Word-by-word block copy engine acting as a second bus initiator.
// Each word is one READ phase (READ_LATENCY+1 cycles) followed by one WRITE cycle.
module bus_dma_initiator #(
  parameter int READ_LATENCY = 1,
  parameter int COUNT_WIDTH  = 16,
  parameter int ADDR_STEP    = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   abort,
  input  logic [31:0]            src_address,
  input  logic [31:0]            dst_address,
  input  logic [COUNT_WIDTH-1:0] word_count,
  output logic                   busy,
  output logic                   done,
  output logic [COUNT_WIDTH-1:0] remaining,
  output logic                   read,
  output logic                   write,
  output logic [31:0]            address,
  output logic [31:0]            write_data,
  input  logic [31:0]            read_data
);

  localparam int WAIT_W = (READ_LATENCY > 0) ? $clog2(READ_LATENCY + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(READ_LATENCY);
  localparam logic [31:0] STEP = 32'(ADDR_STEP);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [WAIT_W-1:0]      wait_q, wait_d;
  logic [COUNT_WIDTH-1:0] remaining_q, remaining_d;
  logic [31:0]            src_q, src_d;
  logic [31:0]            dst_q, dst_d;
  logic [31:0]            buf_q, buf_d;

  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    remaining_d = remaining_q;
    src_d       = src_q;
    dst_d       = dst_q;
    buf_d       = buf_q;
    case (state_q)
      S_IDLE: begin
        // A zero-length request still latches remaining so it reads back as 0.
        if (start) begin
          remaining_d = word_count;
          src_d       = src_address;
          dst_d       = dst_address;
          wait_d      = '0;
          state_d     = (word_count != '0) ? S_READ : S_DONE;
        end
      end
      S_READ: begin
        if (abort) begin
          wait_d  = '0;
          state_d = S_IDLE;
        end else if (wait_q == WAIT_LAST) begin
          buf_d   = read_data;
          wait_d  = '0;
          state_d = S_WRITE;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_WRITE: begin
        remaining_d = remaining_q - COUNT_WIDTH'(1);
        src_d       = src_q + STEP;
        dst_d       = dst_q + STEP;
        if (abort) begin
          state_d = S_IDLE;
        end else if (remaining_d == '0) begin
          state_d = S_DONE;
        end else begin
          state_d = S_READ;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      wait_q      <= '0;
      remaining_q <= '0;
      buf_q       <= '0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      remaining_q <= remaining_d;
      buf_q       <= buf_d;
    end
  end

  // Working addresses are only observed in READ/WRITE, so they need no reset.
  always_ff @(posedge clk) begin
    src_q <= src_d;
    dst_q <= dst_d;
  end

  assign read       = (state_q == S_READ);
  assign write      = (state_q == S_WRITE);
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign remaining  = remaining_q;
  assign write_data = buf_q;
  assign address    = (state_q == S_READ)  ? src_q :
                      (state_q == S_WRITE) ? dst_q : 32'h0;

endmodule

// File: tb/tb_bus_dma_initiator.sv
// Scoreboard bench for bus_dma_initiator with three instances (read latency 0, 1, 3)
// sharing one stimulus driver; a negedge monitor checks bus traffic of the selected one.
module tb_bus_dma_initiator;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          abort;
  logic [31:0]   src_address;
  logic [31:0]   dst_address;
  logic [CW-1:0] word_count;
  int            sel = 1;

  always #5 clk = ~clk;

  logic          busy_v [3];
  logic          done_v [3];
  logic          rd_v   [3];
  logic          wr_v   [3];
  logic [CW-1:0] rem_v  [3];
  logic [31:0]   addr_v [3];
  logic [31:0]   wd_v   [3];

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int L = (g == 0) ? 0 : ((g == 1) ? 1 : 3);
    logic          st, bz, dn, rd, wr;
    logic [CW-1:0] rem;
    logic [31:0]   ad, wd, rdata;

    assign st = start && (sel == g);

    bus_dma_initiator #(.READ_LATENCY(L), .COUNT_WIDTH(CW), .ADDR_STEP(4)) dut (
      .clk(clk), .reset(reset), .start(st), .abort(abort),
      .src_address(src_address), .dst_address(dst_address), .word_count(word_count),
      .busy(bz), .done(dn), .remaining(rem), .read(rd), .write(wr),
      .address(ad), .write_data(wd), .read_data(rdata)
    );

    if (L == 0) begin : g_comb
      assign rdata = memf(ad);
    end else begin : g_pipe
      logic [31:0] pipe [L];
      always @(posedge clk) begin
        pipe[0] <= memf(ad);
        for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
      end
      assign rdata = pipe[L-1];
    end

    assign busy_v[g] = bz;
    assign done_v[g] = dn;
    assign rd_v[g]   = rd;
    assign wr_v[g]   = wr;
    assign rem_v[g]  = rem;
    assign addr_v[g] = ad;
    assign wd_v[g]   = wd;
  end

  logic          m_busy, m_done, m_rd, m_wr;
  logic [CW-1:0] m_rem;
  logic [31:0]   m_addr, m_wd;
  assign m_busy = busy_v[sel];
  assign m_done = done_v[sel];
  assign m_rd   = rd_v[sel];
  assign m_wr   = wr_v[sel];
  assign m_rem  = rem_v[sel];
  assign m_addr = addr_v[sel];
  assign m_wd   = wd_v[sel];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  logic [31:0] exp_rd [$];
  logic [63:0] exp_wr [$];
  logic        rd_prev = 1'b0;

  always @(negedge clk) begin
    logic [63:0] e;
    if (reset) begin
      rd_prev <= 1'b0;
    end else begin
      chk("rd_wr_exclusive", 64'(m_rd & m_wr), 64'(0));
      if (m_rd && !rd_prev) begin
        if (exp_rd.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_read actual=%h required=none", m_addr);
        end else begin
          chk("rd_addr", 64'(m_addr), 64'(exp_rd.pop_front()));
        end
      end
      if (m_wr) begin
        if (exp_wr.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write actual=%h required=none", m_addr);
        end else begin
          e = exp_wr.pop_front();
          chk("wr_addr", 64'(m_addr), 64'(e[63:32]));
          chk("wr_data", 64'(m_wd), 64'(e[31:0]));
        end
      end
      if (!m_rd && !m_wr) chk("idle_addr", 64'(m_addr), 64'(0));
      rd_prev <= m_rd;
    end
  end

  task automatic run_copy(input int k, input logic [31:0] src, input logic [31:0] dst,
                          input int cnt, input int abort_wr, input bit abort_rd,
                          input bit repulse);
    int            lat, nrd, nwr, n, writes;
    bit            aborted, finished;
    logic [CW-1:0] rem_exp;
    lat     = (k == 0) ? 0 : ((k == 1) ? 1 : 3);
    nwr     = abort_rd ? 0 : ((abort_wr > 0) ? abort_wr : cnt);
    nrd     = abort_rd ? 1 : nwr;
    rem_exp = CW'(cnt - nwr);
    for (int i = 0; i < nrd; i++) exp_rd.push_back(src + 32'(4 * i));
    for (int i = 0; i < nwr; i++)
      exp_wr.push_back({dst + 32'(4 * i), memf(src + 32'(4 * i))});
    sel = k;
    @(negedge clk);
    src_address = src;
    dst_address = dst;
    word_count  = CW'(cnt);
    start       = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n = 1; writes = 0; aborted = 0; finished = 0;
    for (int g = 0; g < 4000 && !finished; g++) begin
      @(negedge clk);
      if (aborted) begin
        abort = 1'b0;
        chk("abort_busy", 64'(m_busy), 64'(0));
        chk("abort_done", 64'(m_done), 64'(0));
        chk("abort_rem", 64'(m_rem), 64'(rem_exp));
        finished = 1;
      end else if (m_done) begin
        chk("done_latency", 64'(n), 64'(cnt * (lat + 2) + 1));
        chk("done_rem", 64'(m_rem), 64'(0));
        finished = 1;
      end else begin
        if (m_wr) writes++;
        if (abort_rd && m_rd) begin abort = 1'b1; aborted = 1; end
        if (abort_wr > 0 && m_wr && writes == abort_wr) begin abort = 1'b1; aborted = 1; end
        if (repulse && n == 2) begin
          start       = 1'b1;
          src_address = ~src;
          dst_address = ~dst;
          word_count  = CW'(cnt + 5);
        end
        if (repulse && n == 3) start = 1'b0;
        @(posedge clk);
        n++;
      end
    end
    start = 1'b0;
    abort = 1'b0;
    if (!finished) begin
      checks++; errors++;
      $display("FAIL copy_timeout actual=%0d cycles required=done or abort", n);
    end else if (!aborted) begin
      @(negedge clk);
      chk("post_done_busy", 64'(m_busy), 64'(0));
      chk("post_done_pulse", 64'(m_done), 64'(0));
    end
    chk("queues_drained", 64'(exp_rd.size() + exp_wr.size()), 64'(0));
    exp_rd.delete();
    exp_wr.delete();
  endtask

  initial begin
    int          k, cnt;
    logic [31:0] s, d;
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    src_address = '0; dst_address = '0; word_count = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("rst_busy", 64'(busy_v[i]), 64'(0));
      chk("rst_done", 64'(done_v[i]), 64'(0));
      chk("rst_read", 64'(rd_v[i]), 64'(0));
      chk("rst_write", 64'(wr_v[i]), 64'(0));
      chk("rst_addr", 64'(addr_v[i]), 64'(0));
      chk("rst_wdata", 64'(wd_v[i]), 64'(0));
      chk("rst_rem", 64'(rem_v[i]), 64'(0));
    end
    reset = 1'b0;

    run_copy(1, 32'h100, 32'h200, 3, 0, 0, 0);
    for (int i = 0; i < 3; i++) run_copy(i, 32'h40, 32'h80, 0, 0, 0, 0);
    run_copy(1, 32'hFFFFFFFC, 32'h1000, 2, 0, 0, 0);
    run_copy(1, 32'h500, 32'h600, 4, 2, 0, 0);
    run_copy(2, 32'h700, 32'h800, 3, 0, 1, 0);
    run_copy(0, 32'h900, 32'hA00, 4, 0, 0, 1);
    run_copy(2, 32'hB00, 32'hC00, 3, 0, 0, 1);

    // Asynchronous reset in the middle of a read phase.
    sel = 1;
    exp_rd.push_back(32'h3000);
    @(negedge clk);
    src_address = 32'h3000; dst_address = 32'h4000; word_count = CW'(5); start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    chk("mid_rst_busy", 64'(m_busy), 64'(0));
    chk("mid_rst_read", 64'(m_rd), 64'(0));
    chk("mid_rst_write", 64'(m_wr), 64'(0));
    chk("mid_rst_addr", 64'(m_addr), 64'(0));
    chk("mid_rst_wdata", 64'(m_wd), 64'(0));
    chk("mid_rst_done", 64'(m_done), 64'(0));
    chk("mid_rst_rem", 64'(m_rem), 64'(0));
    #1 reset = 1'b0;
    exp_rd.delete();
    exp_wr.delete();
    run_copy(1, 32'h3000, 32'h4000, 5, 0, 0, 0);

    for (int t = 0; t < 10; t++) begin
      k   = $urandom_range(0, 2);
      cnt = $urandom_range(1, 6);
      s   = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFF0 : ($urandom & 32'hFFFFFFFC);
      d   = $urandom & 32'hFFFFFFFC;
      run_copy(k, s, d, cnt, 0, 0, (cnt >= 2) && ($urandom_range(0, 1) == 1));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
